// File: rtl/bit_serial_sub_pkg.sv
// bit_serial_pkg: shared FSM encoding and counter sizing for the bit-serial subtractor
package bit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter must represent 0..n without wrapping
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bit_serial_sub_fs.sv
// fs: single-bit full subtractor, x - y - bin
module fs (
    input  logic i_x,
    input  logic i_y,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    assign o_d    = i_x ^ i_y ^ i_bin;
    assign o_bout = (~i_x & i_y) | (~(i_x ^ i_y) & i_bin);

endmodule

// File: rtl/bit_serial_sub.sv
// bit_serial_sub: N-bit a - b - bin, one bit per clock LSB first through one fs cell
module bit_serial_sub
    import bit_serial_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_bin,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_diff,
    output logic         o_bout
);

    localparam int CW = cnt_w(N);

    state_t        r_state;
    state_t        w_next;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_diff;
    logic          r_borrow;
    logic          r_bout;
    logic [CW-1:0] r_cnt;
    logic          w_d;
    logic          w_bout;
    logic          w_accept;
    logic          w_last;
    logic [N:0]    w_shift;

    fs u_fs (
        .i_x   (r_a[0]),
        .i_y   (r_b[0]),
        .i_bin (r_borrow),
        .o_d   (w_d),
        .o_bout(w_bout)
    );

    // Start is honoured in IDLE and DONE, never while bits are in flight
    assign w_accept = i_start && (r_state != RUN);
    assign w_last   = (r_cnt == CW'(N - 1));
    // Prepending the new bit and shifting keeps this valid even for N=1
    assign w_shift  = {w_d, r_diff} >> 1;

    assign o_diff = r_diff;
    assign o_bout = r_bout;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and status outputs
    always_comb begin
        w_next = r_state;
        o_busy = (r_state == RUN);
        o_done = (r_state == DONE);
        case (r_state)
            IDLE:    w_next = w_accept ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = w_accept ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand load on accept, then one serial subtract step per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_borrow <= i_bin;
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_borrow <= w_bout;
            r_diff   <= w_shift[N-1:0];
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) r_bout <= w_bout;
        end
    end

endmodule

// File: tb/tb_bit_serial_sub.sv
// tb_bit_serial_sub: scoreboard bench, expected results from plain integer subtraction
module tb_bit_serial_sub;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] diff;
        logic         bout;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         i_start;
    logic [N-1:0] i_a;
    logic [N-1:0] i_b;
    logic         i_bin;
    logic         o_busy;
    logic         o_done;
    logic [N-1:0] o_diff;
    logic         o_bout;

    logic t_x, t_y, t_b, t_d, t_bo;

    exp_t q[$];
    int   cyc;
    int   d_vec, d_err, m_vec, m_err;
    logic prev_done;

    bit_serial_sub #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_start(i_start),
        .i_a    (i_a),
        .i_b    (i_b),
        .i_bin  (i_bin),
        .o_busy (o_busy),
        .o_done (o_done),
        .o_diff (o_diff),
        .o_bout (o_bout)
    );

    fs u_fs (.i_x(t_x), .i_y(t_y), .i_bin(t_b), .o_d(t_d), .o_bout(t_bo));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input int a, input int b, input int bin);
        exp_t e;
        int   r;
        r      = a - b - bin;
        e.diff = r[N-1:0];
        e.bout = (r < 0);
        e.cyc  = 0;
        return e;
    endfunction

    // Monitor: compares every done strobe against the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && o_done) begin
            m_vec++;
            if (prev_done) begin
                m_err++;
                $display("FAIL done_width: done high two cycles in a row at cycle %0d", cyc);
            end
            m_vec++;
            if (q.size() == 0) begin
                m_err++;
                $display("FAIL unexpected_done: done with empty scoreboard at cycle %0d", cyc);
            end else begin
                e = q.pop_front();
                if (o_diff !== e.diff || o_bout !== e.bout) begin
                    m_err++;
                    $display("FAIL result: diff=%0d bout=%0b, expected diff=%0d bout=%0b", o_diff, o_bout, e.diff, e.bout);
                end
                m_vec++;
                if (cyc - e.cyc != N) begin
                    m_err++;
                    $display("FAIL latency: done %0d edges after accept, expected %0d", cyc - e.cyc, N);
                end
            end
        end
        prev_done = rst_n && o_done;
    end

    task automatic wait_not_busy();
        int w;
        w = 0;
        @(negedge clk);
        while (o_busy && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (o_busy) begin
            d_err++;
            $display("FAIL ready_timeout: busy=%0b after %0d cycles, expected 0", o_busy, w);
            $fatal(1, "stuck busy");
        end
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
        exp_t e;
        wait_not_busy();
        i_a     = a;
        i_b     = b;
        i_bin   = bin;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        e     = model(int'(a), int'(b), int'(bin));
        e.cyc = cyc;
        q.push_back(e);
        i_start = 1'b0;
        i_a     = N'($urandom);
        i_b     = N'($urandom);
        i_bin   = 1'($urandom);
        d_vec++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            d_err++;
            $display("FAIL accept: busy=%0b done=%0b, expected busy=1 done=0", o_busy, o_done);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        d_vec++;
        if (q.size() != 0) begin
            d_err++;
            $display("FAIL drain: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        exp_t e;
        int   ndone;
        cyc       = 0;
        d_vec     = 0;
        d_err     = 0;
        m_vec     = 0;
        m_err     = 0;
        prev_done = 1'b0;
        rst_n     = 1'b0;
        i_start   = 1'b0;
        i_a       = '0;
        i_b       = '0;
        i_bin     = 1'b0;
        t_x       = 1'b0;
        t_y       = 1'b0;
        t_b       = 1'b0;

        for (int i = 0; i < 8; i++) begin
            int r;
            {t_x, t_y, t_b} = 3'(i);
            #1;
            r = int'(t_x) - int'(t_y) - int'(t_b);
            d_vec++;
            if (t_d !== r[0] || t_bo !== (r < 0)) begin
                d_err++;
                $display("FAIL fs_cell: x=%0b y=%0b bin=%0b gave d=%0b bout=%0b, expected d=%0b bout=%0b", t_x, t_y, t_b, t_d, t_bo, r[0], r < 0);
            end
        end

        repeat (2) @(negedge clk);
        d_vec++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_diff !== '0 || o_bout !== 1'b0) begin
            d_err++;
            $display("FAIL reset_state: busy=%0b done=%0b diff=%0d bout=%0b, expected all 0", o_busy, o_done, o_diff, o_bout);
        end
        rst_n = 1'b1;

        do_op(4'd2, 4'd3, 1'b0);
        do_op(4'd5, 4'd4, 1'b1);
        do_op(4'd9, 4'd3, 1'b0);
        do_op(4'd0, 4'd0, 1'b1);
        do_op(4'd15, 4'd15, 1'b0);
        drain();

        // Start held high: ignored through RUN, accepted again in DONE
        @(negedge clk);
        i_a     = 4'd7;
        i_b     = 4'd2;
        i_bin   = 1'b0;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        e     = model(7, 2, 0);
        e.cyc = cyc;
        q.push_back(e);
        i_a = 4'd3;
        i_b = 4'd5;
        repeat (N) @(posedge clk);
        #1;
        d_vec++;
        if (o_done !== 1'b1) begin
            d_err++;
            $display("FAIL b2b_done: done=%0b, expected 1", o_done);
        end
        @(posedge clk);
        #1;
        e     = model(3, 5, 0);
        e.cyc = cyc;
        q.push_back(e);
        i_start = 1'b0;
        d_vec++;
        if (o_busy !== 1'b1) begin
            d_err++;
            $display("FAIL b2b_accept: busy=%0b, expected 1", o_busy);
        end
        drain();

        // Isolated start pulse in the middle of RUN must not disturb the result
        do_op(4'd12, 4'd6, 1'b1);
        @(negedge clk);
        i_a     = 4'd1;
        i_b     = 4'd14;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        drain();

        // Asynchronous reset during the second RUN cycle
        do_op(4'd2, 4'd3, 1'b0);
        drain();
        @(negedge clk);
        i_a     = 4'd9;
        i_b     = 4'd3;
        i_bin   = 1'b0;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        d_vec++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_diff !== '0 || o_bout !== 1'b0) begin
            d_err++;
            $display("FAIL mid_run_reset: busy=%0b done=%0b diff=%0d bout=%0b, expected all 0", o_busy, o_done, o_diff, o_bout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_done) ndone++;
        end
        d_vec++;
        if (ndone != 0) begin
            d_err++;
            $display("FAIL reset_abort: %0d done strobes after reset, expected 0", ndone);
        end

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    do_op(N'(a), N'(b), 1'(c));
        drain();

        repeat (40) do_op(N'($urandom), N'($urandom), 1'($urandom));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", d_vec + m_vec, d_err + m_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
